debug_uart_wb_bridge: RTL and testbench

//  SoC-side responder for the debug UART link. Receives framed read/write commands

---
 rtl/debug_uart_wb_bridge.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_debug_uart_wb_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// debug_uart_wb_bridge
//
// SoC-side responder for the debug UART link. The external debug host sends
// framed commands over ser_rx: a command byte (0x01 write, 0x02 read), four
// address bytes MSB first and, for writes, four data bytes MSB first. Each
// command becomes one Wishbone master cycle. The result is sent back over
// ser_tx: 0xAC (ok, followed by four read-data bytes for reads) or 0xEE
// (bus timeout). The bridge only operates while debug_in is high.
//
// Ports
//   core_clk   system clock
//   core_rstn  asynchronous active-low reset
//   debug_in   bridge enable; low drops all in-flight work immediately
//   ser_rx     UART receive line from the host (8N1, LSB first, idle high)
//   ser_tx     UART transmit line to the host (8N1, LSB first, idle high)
//   wb_adr_o   Wishbone address
//   wb_dat_o   Wishbone write data
//   wb_sel_o   byte select, 4'hF while a cycle is active
//   wb_we_o    Wishbone write enable
//   wb_cyc_o   Wishbone cycle
//   wb_stb_o   Wishbone strobe (mirrors wb_cyc_o)
//   wb_dat_i   Wishbone read data
//   wb_ack_i   Wishbone acknowledge
//   busy       a command is being collected, executed or answered
// -----------------------------------------------------------------------------
module debug_uart_wb_bridge #(
   parameter int CLK_DIV    = 347,
   parameter int WB_TIMEOUT = 255
) (
   input  logic        core_clk,
   input  logic        core_rstn,
   input  logic        debug_in,
   input  logic        ser_rx,
   output logic        ser_tx,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        busy
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int TW = $clog2(WB_TIMEOUT + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] TMO_END  = TW'(WB_TIMEOUT - 1);
   localparam logic [7:0]    CMD_WRITE = 8'h01;
   localparam logic [7:0]    CMD_READ  = 8'h02;
   localparam logic [7:0]    RSP_OK    = 8'hAC;
   localparam logic [7:0]    RSP_TMO   = 8'hEE;

   typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_ADDR, P_WDATA, P_BUS, P_RESP} p_state_t;

   // receiver
   rx_state_t     rx_state, rx_next;
   logic          rx_meta, rx_sync, rx_last;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sh;
   logic          rx_valid, rx_ferr;
   logic          rx_tick;

   // transmitter
   tx_state_t     tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_sh;
   logic          tx_tick, tx_ready, tx_go, tx_line;

   // command parser and bus master
   p_state_t      p_state, p_next;
   logic [1:0]    byte_cnt;
   logic          is_write;
   logic [31:0]   adr_q, dat_q;
   logic          cyc_q;
   logic [TW-1:0] tmo_cnt;
   logic [39:0]   resp_sh;
   logic [2:0]    resp_left;
   logic          bus_end;

   // Two-flop synchroniser plus one extra stage so a falling edge on the
   // synchronised line can be detected.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_last <= 1'b1;
      end else begin
         rx_meta <= ser_rx;
         rx_sync <= rx_meta;
         rx_last <= rx_sync;
      end
   end

   assign rx_tick = (rx_cnt == BIT_END);

   // Receiver state register.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) rx_state <= RX_HUNT;
      else            rx_state <= rx_next;
   end

   // Receiver next state: a falling edge arms the start check half a bit
   // later, which also places every later sample at a bit centre.
   always_comb begin
      rx_next = rx_state;
      if (!debug_in) begin
         rx_next = RX_HUNT;
      end else begin
         case (rx_state)
            RX_HUNT:  if (rx_last && !rx_sync) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_END) rx_next = rx_sync ? RX_HUNT : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_HUNT;
            default:  rx_next = RX_HUNT;
         endcase
      end
   end

   // Receiver datapath: bit timer, shift register and the one-cycle
   // byte-valid / framing-error strobes towards the parser.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (rx_state == RX_HUNT || rx_state != rx_next || rx_tick) rx_cnt <= '0;
         else                                                       rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_START) rx_bit <= '0;
         if (rx_state == RX_DATA && rx_tick) begin
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
         end
         if (rx_state == RX_STOP && rx_tick && debug_in) begin
            rx_valid <= rx_sync;
            rx_ferr  <= ~rx_sync;
         end
      end
   end

   // The bus cycle ends on ack, or on the last allowed cycle; ack wins a tie.
   assign bus_end = cyc_q && (wb_ack_i || tmo_cnt == TMO_END);

   // Parser state register.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) p_state <= P_IDLE;
      else            p_state <= p_next;
   end

   // Parser next state and the request to the transmitter.
   always_comb begin
      p_next = p_state;
      tx_go  = 1'b0;
      if (!debug_in) begin
         p_next = P_IDLE;
      end else begin
         case (p_state)
            P_IDLE:
               if (rx_valid && (rx_sh == CMD_WRITE || rx_sh == CMD_READ)) p_next = P_ADDR;
            P_ADDR:
               if (rx_ferr) p_next = P_IDLE;
               else if (rx_valid && byte_cnt == 2'd3) p_next = is_write ? P_WDATA : P_BUS;
            P_WDATA:
               if (rx_ferr) p_next = P_IDLE;
               else if (rx_valid && byte_cnt == 2'd3) p_next = P_BUS;
            P_BUS:
               if (bus_end) p_next = P_RESP;
            P_RESP: begin
               tx_go = (resp_left != 3'd0);
               if (resp_left == 3'd0 && tx_state == TX_IDLE) p_next = P_IDLE;
            end
            default: p_next = P_IDLE;
         endcase
      end
   end

   // Parser datapath: collects address/data bytes, runs the Wishbone cycle
   // (cyc rises one cycle after entering BUS so address and data are already
   // stable) and prepares the response bytes for the transmitter.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         byte_cnt  <= '0;
         is_write  <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         cyc_q     <= 1'b0;
         tmo_cnt   <= '0;
         resp_sh   <= '0;
         resp_left <= '0;
      end else if (!debug_in) begin
         cyc_q     <= 1'b0;
         resp_left <= '0;
      end else begin
         case (p_state)
            P_IDLE:
               if (rx_valid) begin
                  is_write <= (rx_sh == CMD_WRITE);
                  byte_cnt <= '0;
               end
            P_ADDR:
               if (rx_valid) begin
                  adr_q    <= {adr_q[23:0], rx_sh};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            P_WDATA:
               if (rx_valid) begin
                  dat_q    <= {dat_q[23:0], rx_sh};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            P_BUS:
               if (!cyc_q) begin
                  cyc_q   <= 1'b1;
                  tmo_cnt <= '0;
               end else if (wb_ack_i) begin
                  cyc_q     <= 1'b0;
                  resp_sh   <= is_write ? {RSP_OK, 32'h0} : {RSP_OK, wb_dat_i};
                  resp_left <= is_write ? 3'd1 : 3'd5;
               end else if (tmo_cnt == TMO_END) begin
                  cyc_q     <= 1'b0;
                  resp_sh   <= {RSP_TMO, 32'h0};
                  resp_left <= 3'd1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            P_RESP:
               if (tx_go && tx_ready) begin
                  resp_sh   <= {resp_sh[31:0], 8'h00};
                  resp_left <= resp_left - 3'd1;
               end
            default: ;
         endcase
      end
   end

   assign tx_tick  = (tx_cnt == BIT_END);
   // A new byte may be loaded when idle or in the last cycle of a stop bit,
   // which keeps consecutive response bytes back-to-back.
   assign tx_ready = (tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick);

   // Transmitter state register.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) tx_state <= TX_IDLE;
      else            tx_state <= tx_next;
   end

   // Transmitter next state and line level.
   always_comb begin
      tx_next = tx_state;
      tx_line = 1'b1;
      case (tx_state)
         TX_IDLE:  if (tx_go) tx_next = TX_START;
         TX_START: begin
            tx_line = 1'b0;
            if (tx_tick) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_sh[0];
            if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         end
         TX_STOP:  if (tx_tick) tx_next = tx_go ? TX_START : TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
      if (!debug_in) tx_next = TX_IDLE;
   end

   // Transmitter datapath: bit timer and output shift register.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
      end else begin
         if (tx_state == TX_IDLE || tx_state != tx_next || tx_tick) tx_cnt <= '0;
         else                                                       tx_cnt <= tx_cnt + 1'b1;
         if (tx_go && tx_ready) begin
            tx_sh  <= resp_sh[39:32];
            tx_bit <= '0;
         end else if (tx_state == TX_DATA && tx_tick) begin
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_bit <= tx_bit + 1'b1;
         end
      end
   end

   // debug_in gates the visible outputs directly so that dropping it takes
   // effect in the same cycle, ahead of the registered clean-up.
   assign ser_tx   = tx_line | ~debug_in;
   assign wb_cyc_o = cyc_q & debug_in;
   assign wb_stb_o = wb_cyc_o;
   assign wb_we_o  = wb_cyc_o & is_write;
   assign wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign busy     = debug_in && (p_state != P_IDLE);

endmodule

// File: tb/tb_debug_uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_debug_uart_wb_bridge
//
// Drives host commands into debug_uart_wb_bridge over a bit-banged UART,
// plays a Wishbone slave with a programmable ack delay, decodes the bytes
// coming back on ser_tx and compares everything against the outcome predicted
// from the protocol rules (ok when the ack arrives within the timeout window,
// otherwise 0xEE).
// -----------------------------------------------------------------------------
module tb_debug_uart_wb_bridge;

   localparam int BIT = 16;
   localparam int TMO = 20;
   localparam int NEVER = 1000;

   logic        core_clk = 1'b0;
   logic        core_rstn;
   logic        debug_in;
   logic        ser_rx;
   logic        ser_tx;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, busy;

   int vectors = 0;
   int miscompares = 0;

   // Wishbone slave configuration and observations
   int          ackDelay = NEVER;
   logic [31:0] slaveRd = 32'h0;
   int          cycHigh = 0;
   int          lastCycLen = 0;
   int          busCount = 0;
   logic [31:0] busAdr, busDat;
   logic        busWe, busStb;
   logic [3:0]  busSel;

   // UART decoder output
   logic [7:0] txQ[$];
   logic [7:0] monByte;
   int         txStopErr = 0;

   debug_uart_wb_bridge #(.CLK_DIV(BIT), .WB_TIMEOUT(TMO)) dut (
      .core_clk (core_clk),
      .core_rstn(core_rstn),
      .debug_in (debug_in),
      .ser_rx   (ser_rx),
      .ser_tx   (ser_tx),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .busy     (busy)
   );

   always #5 core_clk = ~core_clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Wishbone slave: records the first cycle of each access, acks after
   // ackDelay cycles of cyc and presents read data only alongside ack.
   initial begin
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      forever begin
         @(negedge core_clk);
         if (wb_cyc_o === 1'b1) begin
            cycHigh++;
            if (cycHigh == 1) begin
               busCount++;
               busAdr = wb_adr_o;
               busDat = wb_dat_o;
               busWe  = wb_we_o;
               busSel = wb_sel_o;
               busStb = wb_stb_o;
            end
            if (!wb_ack_i && cycHigh >= ackDelay) begin
               wb_ack_i = 1'b1;
               wb_dat_i = slaveRd;
            end else begin
               wb_ack_i = 1'b0;
               wb_dat_i = $urandom;
            end
         end else begin
            if (cycHigh != 0) lastCycLen = cycHigh;
            cycHigh  = 0;
            wb_ack_i = 1'b0;
            wb_dat_i = $urandom;
         end
      end
   end

   // UART decoder for ser_tx.
   initial begin
      forever begin
         @(negedge ser_tx);
         repeat (BIT / 2) @(negedge core_clk);
         if (ser_tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge core_clk);
               monByte[i] = ser_tx;
            end
            repeat (BIT) @(negedge core_clk);
            if (ser_tx !== 1'b1) txStopErr++;
            txQ.push_back(monByte);
         end
      end
   end

   // Host-side UART transmit of one frame with a chosen stop-bit level.
   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      @(negedge core_clk);
      ser_rx = 1'b0;
      repeat (BIT) @(negedge core_clk);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (BIT) @(negedge core_clk);
      end
      ser_rx = stopBit;
      repeat (BIT) @(negedge core_clk);
      ser_rx = 1'b1;
   endtask

   task automatic waitIdle(input string tag);
      for (int i = 0; i < 6000 && busy !== 1'b0; i++) @(negedge core_clk);
      checkOutput({tag, "_idle"}, busy, 1'b0);
      repeat (4) @(negedge core_clk);
   endtask

   // One complete command/response exchange checked against the protocol.
   task automatic applyStimulus(input string tag, input logic isWrite, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [31:0] rd, input int delay);
      logic [7:0] expResp[$];
      int         baseCount, baseStop;
      logic       expOk;
      int         expLen;
      ackDelay = delay;
      slaveRd  = rd;
      txQ.delete();
      baseCount = busCount;
      baseStop  = txStopErr;
      sendByte(isWrite ? 8'h01 : 8'h02, 1'b1);
      for (int i = 3; i >= 0; i--) sendByte(adr[i*8 +: 8], 1'b1);
      if (isWrite) for (int i = 3; i >= 0; i--) sendByte(dat[i*8 +: 8], 1'b1);
      waitIdle(tag);

      expOk  = (delay >= 1) && (delay <= TMO);
      expLen = expOk ? delay : TMO;
      if (!expOk) expResp.push_back(8'hEE);
      else begin
         expResp.push_back(8'hAC);
         if (!isWrite) for (int i = 3; i >= 0; i--) expResp.push_back(rd[i*8 +: 8]);
      end

      checkOutput({tag, "_buscount"}, 64'(busCount - baseCount), 64'd1);
      checkOutput({tag, "_adr"}, busAdr, adr);
      checkOutput({tag, "_we"}, busWe, isWrite);
      checkOutput({tag, "_sel"}, busSel, 4'hF);
      checkOutput({tag, "_stb"}, busStb, 1'b1);
      if (isWrite) checkOutput({tag, "_dat"}, busDat, dat);
      checkOutput({tag, "_cyclen"}, 64'(lastCycLen), 64'(expLen));
      checkOutput({tag, "_resplen"}, 64'(txQ.size()), 64'(expResp.size()));
      for (int i = 0; i < expResp.size(); i++)
         checkOutput($sformatf("%s_resp%0d", tag, i), (i < txQ.size()) ? {56'h0, txQ[i]} : 64'hFFFF, {56'h0, expResp[i]});
      checkOutput({tag, "_txstop"}, 64'(txStopErr - baseStop), 64'd0);
   endtask

   // Starts a read that never gets acked and waits until cyc is up.
   task automatic startHungRead(input string tag);
      ackDelay = NEVER;
      sendByte(8'h02, 1'b1);
      sendByte(8'h11, 1'b1);
      sendByte(8'h22, 1'b1);
      sendByte(8'h33, 1'b1);
      sendByte(8'h44, 1'b1);
      for (int i = 0; i < 200 && wb_cyc_o !== 1'b1; i++) @(negedge core_clk);
      checkOutput({tag, "_cycup"}, wb_cyc_o, 1'b1);
      repeat (3) @(negedge core_clk);
   endtask

   initial begin
      #1_200_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a, d, r;
      logic        w;
      int          dly, pick;
      core_rstn = 1'b0;
      debug_in  = 1'b1;
      ser_rx    = 1'b1;
      repeat (3) @(negedge core_clk);
      checkOutput("rst_sertx", ser_tx, 1'b1);
      checkOutput("rst_cyc", wb_cyc_o, 1'b0);
      checkOutput("rst_stb", wb_stb_o, 1'b0);
      checkOutput("rst_we", wb_we_o, 1'b0);
      checkOutput("rst_adr", wb_adr_o, 32'h0);
      checkOutput("rst_dat", wb_dat_o, 32'h0);
      checkOutput("rst_sel", wb_sel_o, 4'h0);
      checkOutput("rst_busy", busy, 1'b0);
      core_rstn = 1'b1;
      repeat (2 * BIT) @(negedge core_clk);

      $display("[TB] directed write and read");
      applyStimulus("wr", 1'b1, 32'h2600000C, 32'h0000AB00, 32'h0, 3);
      applyStimulus("rd", 1'b0, 32'h26000010, 32'h0, 32'h12345678, 1);
      applyStimulus("tmo", 1'b0, 32'h26000010, 32'h0, 32'h0, NEVER);
      applyStimulus("tie", 1'b0, 32'hCAFE0004, 32'h0, 32'hA5A55A5A, TMO);
      applyStimulus("late", 1'b1, 32'hCAFE0008, 32'h01020304, 32'h0, TMO + 1);

      $display("[TB] unknown command byte");
      sendByte(8'h7F, 1'b1);
      repeat (2 * BIT) @(negedge core_clk);
      checkOutput("bad_busy", busy, 1'b0);
      applyStimulus("bad_wr", 1'b1, 32'h00000040, 32'hDEADBEEF, 32'h0, 2);

      $display("[TB] framing error mid-command");
      sendByte(8'h02, 1'b1);
      sendByte(8'h26, 1'b1);
      sendByte(8'h00, 1'b0);
      repeat (2 * BIT) @(negedge core_clk);
      checkOutput("ferr_busy", busy, 1'b0);
      applyStimulus("ferr_rd", 1'b0, 32'h26000010, 32'h0, 32'h0BADF00D, 4);

      $display("[TB] debug_in drop during bus cycle");
      startHungRead("dbg");
      debug_in = 1'b0;
      #1;
      checkOutput("dbg_cyc", wb_cyc_o, 1'b0);
      checkOutput("dbg_stb", wb_stb_o, 1'b0);
      checkOutput("dbg_sertx", ser_tx, 1'b1);
      checkOutput("dbg_busy", busy, 1'b0);
      repeat (4) @(negedge core_clk);
      debug_in = 1'b1;
      repeat (2 * BIT) @(negedge core_clk);
      checkOutput("dbg_after_busy", busy, 1'b0);
      applyStimulus("dbg_rd", 1'b0, 32'h00001000, 32'h0, 32'h87654321, 2);

      $display("[TB] reset during bus cycle");
      startHungRead("rst");
      core_rstn = 1'b0;
      #1;
      checkOutput("rst2_cyc", wb_cyc_o, 1'b0);
      checkOutput("rst2_stb", wb_stb_o, 1'b0);
      checkOutput("rst2_sertx", ser_tx, 1'b1);
      checkOutput("rst2_busy", busy, 1'b0);
      checkOutput("rst2_adr", wb_adr_o, 32'h0);
      repeat (4) @(negedge core_clk);
      core_rstn = 1'b1;
      repeat (2 * BIT) @(negedge core_clk);
      applyStimulus("rst_wr", 1'b1, 32'h00002000, 32'h13579BDF, 32'h0, 1);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 10; n++) begin
         w = 1'($urandom_range(0, 1));
         a = $urandom;
         d = $urandom;
         r = $urandom;
         pick = $urandom_range(0, 7);
         if (pick <= 3)      dly = $urandom_range(1, 6);
         else if (pick == 4) dly = TMO - 1;
         else if (pick == 5) dly = TMO;
         else if (pick == 6) dly = TMO + 1;
         else                dly = NEVER;
         applyStimulus($sformatf("rnd%0d", n), w, a, d, r, dly);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
